// File: rtl/tatsujin_pkg.sv
// ---------------------------------------------------------------------------
// tatsujin_pkg
// Shared types and defaults for the note-lane playback path.
//   seq_state_t    : song_sequencer FSM states
//   tempo_sel_t    : tempo switch encodings (beat period = BASE_DIV >> sel)
//   DEFAULT_*      : default song length, beat index width and base divider
//   period_minus1  : reload value for the beat divider at a given tempo
// ---------------------------------------------------------------------------
package tatsujin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        TEMPO_X1 = 2'd0,
        TEMPO_X2 = 2'd1,
        TEMPO_X4 = 2'd2,
        TEMPO_X8 = 2'd3
    } tempo_sel_t;

    localparam int unsigned DEFAULT_BASE_DIV = 25_000_000;
    localparam int unsigned DEFAULT_SONG_LEN = 100;
    localparam int unsigned DEFAULT_BEAT_W   = 7;

    function automatic int unsigned period_minus1(input int unsigned base_div,
                                                  input logic [1:0]  sel);
        return (base_div >> sel) - 1;
    endfunction

endpackage

// File: rtl/beat_divider.sv
// ---------------------------------------------------------------------------
// beat_divider
// Loadable down-counter that paces the beats of a song.
//   clk, reset : system clock, async active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over freeze)
//   load_val   : reload value (beat period minus one)
//   freeze     : hold the count
//   zero, one  : decodes of the current count
// ---------------------------------------------------------------------------
module beat_divider #(
    parameter int unsigned W = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         freeze,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt;

    // Terminal count is normally serviced by a reload; the guard only stops a
    // wrap if the counter is ever left running at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!freeze && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == W'(1));

endmodule

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Playback controller for the three note lanes: reloads the lanes on start,
// then issues one lane shift per beat at the switch-selected tempo, with a
// scoring-window strobe one cycle ahead and a redraw request after each shift.
//   clk, reset    : system clock, async active-high reset
//   start         : level; starts (or replays) a song from IDLE/DONE
//   pause         : level; freezes playback while high
//   tempo_sel     : beat period = BASE_DIV >> tempo_sel, latched at load
//   redraw_ack    : renderer accepts the pending redraw
//   load_song     : pulse, lanes reload the song image
//   shift_en      : pulse, lanes shift by one note
//   judge_strobe  : pulse one cycle before shift_en, closes the hit window
//   redraw_req    : held until acknowledged
//   beat_idx      : beats elapsed since load
//   playing, done : PLAY/PAUSED and DONE indicators
//   overrun       : sticky, a redraw was still pending when a new one came due
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | one cycle: reload lanes, latch tempo, arm divider
// PLAY   | divider running, one shift per beat
// PAUSED | divider and beat count frozen
// DONE   | song finished, waiting for start to replay
// ---------------------------------------------------------------------------
module song_sequencer
    import tatsujin_pkg::*;
#(
    parameter int unsigned SONG_LEN = DEFAULT_SONG_LEN,
    parameter int unsigned BEAT_W   = DEFAULT_BEAT_W,
    parameter int unsigned BASE_DIV = DEFAULT_BASE_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic [1:0]        tempo_sel,
    input  logic              redraw_ack,
    output logic              load_song,
    output logic              shift_en,
    output logic              judge_strobe,
    output logic              redraw_req,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              playing,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned       DIV_W     = $clog2(BASE_DIV + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [DIV_W-1:0]  period_m1;
    logic [DIV_W-1:0]  div_load_val;
    logic              div_load;
    logic              div_freeze;
    logic              div_zero;
    logic              div_one;
    logic [BEAT_W-1:0] beat_next;
    logic              last_beat;

    assign beat_next = beat_idx + BEAT_ONE;
    assign last_beat = (beat_next == LAST_BEAT);

    // Divider control. In LOAD the period comes straight from the switches so
    // the first beat already runs at the new tempo.
    always_comb begin
        div_load     = 1'b0;
        div_load_val = period_m1;
        if (state == ST_LOAD) begin
            div_load     = 1'b1;
            div_load_val = DIV_W'(period_minus1(BASE_DIV, tempo_sel));
        end else if ((state == ST_PLAY) && div_zero) begin
            div_load     = 1'b1;
        end
    end

    assign div_freeze = (state != ST_PLAY);

    beat_divider #(
        .W (DIV_W)
    ) u_beat_divider (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .load_val (div_load_val),
        .freeze   (div_freeze),
        .zero     (div_zero),
        .one      (div_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A beat that lands while pause is high still shifts; the final beat
    // always goes to DONE regardless of pause.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_PLAY;
            ST_PLAY: begin
                if (div_zero && last_beat) begin
                    state_next = ST_DONE;
                end else if (pause) begin
                    state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: if (!pause) state_next = ST_PLAY;
            ST_DONE:   if (start) state_next = ST_LOAD;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load_song    = (state == ST_LOAD);
        shift_en     = (state == ST_PLAY) && div_zero;
        judge_strobe = (state == ST_PLAY) && div_one;
        playing      = (state == ST_PLAY) || (state == ST_PAUSED);
        done         = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_m1 <= DIV_W'(BASE_DIV - 1);
            beat_idx  <= '0;
        end else if (state == ST_LOAD) begin
            period_m1 <= div_load_val;
            beat_idx  <= '0;
        end else if (shift_en) begin
            beat_idx  <= beat_next;
        end
    end

    // Redraw handshake. Shifts are never held off by the renderer: a new
    // event on top of an unserviced request merges into it and flags overrun.
    // A pending request from the previous song is simply absorbed by the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redraw_req <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load_song || shift_en) begin
                redraw_req <= 1'b1;
            end else if (redraw_ack) begin
                redraw_req <= 1'b0;
            end

            if (state == ST_LOAD) begin
                overrun <= 1'b0;
            end else if (shift_en && redraw_req && !redraw_ack) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
